// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the writeback requesters and the register-file write arbiter.
// The arbiter takes the slave modport. The requester side or bench takes the master modport.
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] waddr_in;
    logic [8*NREQ-1:0] wdata_in;
    logic [NREQ-1:0]   gnt;
    logic              rf_we;
    logic [2:0]        rf_waddr;
    logic [7:0]        rf_wdata;
    logic              init_done;

    modport master (
        output req, waddr_in, wdata_in,
        input  gnt, rf_we, rf_waddr, rf_wdata, init_done
    );

    modport slave (
        input  req, waddr_in, wdata_in,
        output gnt, rf_we, rf_waddr, rf_wdata, init_done
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the single 8x8 register-file write port. After reset it sweeps INIT_VAL into R0..R7.
// It then arbitrates NREQ writeback requesters, round-robin by default or fixed priority with ARB_FIXED_PRIO_EN.
module regfile_wr_arbiter #(
    parameter int         NREQ     = 3,
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wr_arbiter_if.slave    bus
);
    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [0:0] {S_INIT, S_ARB} state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rf_we_q, rf_we_d;
    logic [2:0]      rf_waddr_q, rf_waddr_d;
    logic [7:0]      rf_wdata_q, rf_wdata_d;
    logic            init_done_q, init_done_d;
`ifndef ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    logic [NREQ-1:0]  elig;
    logic             win_found;
    logic [PTR_W-1:0] win_idx;

    // A requester granted in the current cycle is masked, so a held req cannot write twice.
    assign elig = bus.req & ~gnt_q;

    always_comb begin
        int cand;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
`endif
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        init_done_d = init_done_q;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            S_INIT: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = INIT_VAL;
                cnt_d      = 3'(cnt_q + 3'd1);
                if (cnt_q == 3'd7) begin
                    state_d     = S_ARB;
                    init_done_d = 1'b1;
                end
            end
            S_ARB: begin
                if (win_found) begin
                    gnt_d      = NREQ'(1) << win_idx;
                    rf_we_d    = 1'b1;
                    rf_waddr_d = bus.waddr_in[3*int'(win_idx) +: 3];
                    rf_wdata_d = bus.wdata_in[8*int'(win_idx) +: 8];
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr_d   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : PTR_W'(win_idx + 1'b1);
`endif
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            init_done_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            init_done_q <= init_done_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.init_done = init_done_q;
endmodule
